// File: rtl/fir_rns_seq.sv
// -----------------------------------------------------------------------------
// fir_rns_seq
// Block-level sequencer for the RNS FIR filter core. For each block it clears
// the core, streams SIGNAL_LENGTH RNS samples into the core input memory,
// triggers compute, waits for the core done flag and streams the filtered
// samples back out over a valid/ready interface. Data is passed through
// unmodified; no residue arithmetic happens here.
//
// Optional feature macro: FIR_RNS_SEQ_TIMEOUT_EN
//   When defined, a watchdog counts cycles in RUN. If the core does not
//   raise fir_done within TIMEOUT_CYCLES, the block is abandoned (back to
//   IDLE) and timeout_err pulses for one cycle. When undefined, RUN waits
//   indefinitely and neither the TIMEOUT_CYCLES parameter, the timeout_err
//   port nor the counter exists.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a block (sampled only in IDLE)
//   busy                high in every state except IDLE
//   in_valid/in_ready   input sample handshake, in_data = 4 x 8-bit residues
//   out_valid/out_ready output sample handshake, out_data registered
//   out_last            marks output index SIGNAL_LENGTH-1
//   block_done          one-cycle pulse after the last output is accepted
//   fir_reset, fir_operation, fir_addr, fir_x_rns   core control/data
//   fir_y_rns, fir_done                             core result/status
//   timeout_err         watchdog pulse (FIR_RNS_SEQ_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module fir_rns_seq #(
`ifdef FIR_RNS_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 500000,
`endif
  parameter int SIGNAL_LENGTH = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        block_done,
  output logic        fir_reset,
  output logic [1:0]  fir_operation,
  output logic [31:0] fir_addr,
  output logic [31:0] fir_x_rns,
  input  logic [31:0] fir_y_rns,
`ifdef FIR_RNS_SEQ_TIMEOUT_EN
  input  logic        fir_done,
  output logic        timeout_err
`else
  input  logic        fir_done
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_RD_REQ = 3'd4;
  localparam logic [2:0] ST_RD_CAP = 3'd5;
  localparam logic [2:0] ST_OUT    = 3'd6;

  localparam logic [31:0] LAST_IDX = 32'(SIGNAL_LENGTH - 32'sd1);

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [31:0] load_cnt_r;
  logic [31:0] rd_cnt_r;
  logic [31:0] out_data_r;
  logic        block_done_r;
  logic        load_acc_s;
  logic        out_acc_s;
  logic        load_last_s;
  logic        rd_last_s;
  logic        tmo_hit_s;

  assign load_acc_s  = (state_r == ST_LOAD) && in_valid;
  assign out_acc_s   = (state_r == ST_OUT) && out_ready;
  assign load_last_s = (load_cnt_r == LAST_IDX);
  assign rd_last_s   = (rd_cnt_r == LAST_IDX);

`ifdef FIR_RNS_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 32'sd1);

  logic [31:0] tmo_cnt_r;
  logic        timeout_err_r;

  // Watchdog hits on the last allowed RUN cycle without fir_done.
  assign tmo_hit_s = (state_r == ST_RUN) && !fir_done && (tmo_cnt_r == TMO_LAST);

  // Watchdog counter runs only while in RUN, restarts on every RUN entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= 32'd0;
    end else if ((state_r == ST_RUN) && !fir_done) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_r <= 32'd0;
    end
  end

  // One-cycle timeout pulse, registered from the hit condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= tmo_hit_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state decode of the block sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_CLEAR;
        else       state_nxt_s = ST_IDLE;
      end
      ST_CLEAR: state_nxt_s = ST_LOAD;
      ST_LOAD: begin
        if (load_acc_s && load_last_s) state_nxt_s = ST_RUN;
        else                           state_nxt_s = ST_LOAD;
      end
      ST_RUN: begin
        // fir_done takes priority over a watchdog hit in the same cycle
        if (fir_done)       state_nxt_s = ST_RD_REQ;
        else if (tmo_hit_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_RUN;
      end
      ST_RD_REQ: state_nxt_s = ST_RD_CAP;
      ST_RD_CAP: state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (out_acc_s && rd_last_s) state_nxt_s = ST_IDLE;
        else if (out_acc_s)         state_nxt_s = ST_RD_REQ;
        else                        state_nxt_s = ST_OUT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Load and read-back counters; cleared at the start of every block.
  always_ff @(posedge clk) begin
    if (reset || (state_r == ST_CLEAR)) begin
      load_cnt_r <= 32'd0;
      rd_cnt_r   <= 32'd0;
    end else begin
      if (load_acc_s) begin
        load_cnt_r <= load_cnt_r + 32'd1;
      end
      if (out_acc_s && !rd_last_s) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
    end
  end

  // Output sample register: captures core data one cycle after the read request.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r <= 32'd0;
    end else if (state_r == ST_RD_CAP) begin
      out_data_r <= fir_y_rns;
    end
  end

  // Block completion pulse, the cycle after the final output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_done_r <= 1'b0;
    end else begin
      block_done_r <= out_acc_s && rd_last_s;
    end
  end

  // Core control decode; everything idles at zero unless a state drives it.
  always_comb begin
    fir_operation = 2'b00;
    fir_addr      = 32'd0;
    fir_x_rns     = 32'd0;
    case (state_r)
      ST_LOAD: begin
        if (in_valid) begin
          fir_operation = 2'b01;
          fir_addr      = load_cnt_r;
          fir_x_rns     = in_data;
        end else begin
          fir_operation = 2'b00;
        end
      end
      ST_RUN:    fir_operation = 2'b10;
      ST_RD_REQ: begin
        fir_operation = 2'b11;
        fir_addr      = rd_cnt_r;
      end
      default:   fir_operation = 2'b00;
    endcase
  end

  assign busy       = (state_r != ST_IDLE);
  assign in_ready   = (state_r == ST_LOAD);
  assign out_valid  = (state_r == ST_OUT);
  assign out_last   = (state_r == ST_OUT) && rd_last_s;
  assign fir_reset  = (state_r == ST_CLEAR);
  assign out_data   = out_data_r;
  assign block_done = block_done_r;

endmodule

// File: tb/tb_fir_rns_seq.sv
// Self-checking bench for fir_rns_seq with a behavioural RNS FIR core
// (n=4 taps, 8 samples per block) and a direct-form reference model.
module tb_fir_rns_seq;
  localparam int L          = 8;
  localparam int NTAP       = 4;
  localparam int RUN_CYCLES = L * (4 * NTAP + 1) + 1;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [31:0] in_data;
  logic        busy, in_ready, out_valid, out_last, block_done, fir_reset;
  logic [31:0] out_data, fir_addr, fir_x_rns;
  logic [1:0]  fir_operation;
  logic [31:0] fir_y_rns = 32'd0;
  logic        fir_done  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef FIR_RNS_SEQ_TIMEOUT_EN
  logic m_tmo_err;
`endif

  fir_rns_seq #(.SIGNAL_LENGTH(L)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .block_done(block_done), .fir_reset(fir_reset),
    .fir_operation(fir_operation), .fir_addr(fir_addr), .fir_x_rns(fir_x_rns),
    .fir_y_rns(fir_y_rns),
`ifdef FIR_RNS_SEQ_TIMEOUT_EN
    .fir_done(fir_done), .timeout_err(m_tmo_err)
`else
    .fir_done(fir_done)
`endif
  );

  // ---------------- reference arithmetic ----------------
  function automatic int modulus(input int k);
    case (k)
      0: return 233;
      1: return 239;
      2: return 241;
      default: return 251;
    endcase
  endfunction

  function automatic int coef(input int i);
    case (i)
      0: return 3;
      1: return 5;
      2: return 7;
      default: return 11;
    endcase
  endfunction

  // y[j] = sum_i c[i]*x[j-i] mod m, independently in each residue lane
  function automatic logic [31:0] fir_out(input logic [31:0] x [L], input int j);
    logic [31:0] y;
    int acc;
    y = 32'd0;
    for (int k = 0; k < 4; k++) begin
      acc = 0;
      for (int i = 0; i < NTAP; i++)
        if (j - i >= 0) acc += coef(i) * int'(x[j-i][8*k +: 8]);
      y[8*k +: 8] = 8'(acc % modulus(k));
    end
    return y;
  endfunction

  function automatic logic [31:0] rand_sample();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = 8'($urandom_range(modulus(k) - 1, 0));
    return v;
  endfunction

  // ---------------- behavioural core ----------------
  logic [31:0] core_x [L];
  int          core_run = 0;

  always @(posedge clk) begin
    if (fir_reset === 1'b1) begin
      for (int i = 0; i < L; i++) core_x[i] <= 32'd0;
      core_run <= 0;
      fir_done <= 1'b0;
    end else begin
      case (fir_operation)
        2'b01: if (fir_addr < L) core_x[fir_addr[2:0]] <= fir_x_rns;
        2'b10: if (!fir_done) begin
          if (core_run == RUN_CYCLES - 1) fir_done <= 1'b1;
          core_run <= core_run + 1;
        end
        2'b11: fir_y_rns <= (fir_addr < L) ? fir_out(core_x, int'(fir_addr)) : 32'd0;
        default: ;
      endcase
    end
  end

  // ---------------- monitor (samples at negedge) ----------------
  int          ncyc = 0, op10_nd = 0, done_cnt = 0, stab_err = 0, last_err = 0, clr_cnt = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] out_q [$];
  logic        last_q [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'd0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (fir_operation === 2'b01) begin
      wr_addr_q.push_back(fir_addr);
      wr_data_q.push_back(fir_x_rns);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      out_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (block_done === 1'b1) done_cnt = done_cnt + 1;
    if (fir_reset === 1'b1) clr_cnt = clr_cnt + 1;
    if (fir_operation === 2'b10 && fir_done === 1'b0) op10_nd = op10_nd + 1;
    if (out_last === 1'b1 && out_valid !== 1'b1) last_err = last_err + 1;
    if (prev_stall && reset === 1'b0 && (out_valid !== 1'b1 || out_data !== prev_data))
      stab_err = stab_err + 1;
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_data  = out_data;
  end

`ifdef FIR_RNS_SEQ_TIMEOUT_EN
  // Second instance with a short watchdog and a core that never finishes.
  logic        t_start = 1'b0;
  logic        t_busy, t_in_ready, t_out_valid, t_out_last, t_block_done, t_fir_reset, t_err;
  logic [31:0] t_out_data, t_fir_addr, t_fir_x_rns;
  logic [1:0]  t_fir_op;
  int          t_run_at = 0, t_err_at = 0, t_err_cnt = 0, t_ov_cnt = 0;
  logic [1:0]  t_prev_op = 2'b00;

  fir_rns_seq #(.TIMEOUT_CYCLES(50), .SIGNAL_LENGTH(L)) dut_tmo (
    .clk(clk), .reset(reset), .start(t_start), .busy(t_busy),
    .in_valid(1'b1), .in_ready(t_in_ready), .in_data(32'h01020304),
    .out_valid(t_out_valid), .out_ready(1'b1), .out_data(t_out_data),
    .out_last(t_out_last), .block_done(t_block_done), .fir_reset(t_fir_reset),
    .fir_operation(t_fir_op), .fir_addr(t_fir_addr), .fir_x_rns(t_fir_x_rns),
    .fir_y_rns(32'd0), .fir_done(1'b0), .timeout_err(t_err)
  );

  always @(negedge clk) begin
    if (t_fir_op === 2'b10 && t_prev_op !== 2'b10) t_run_at = ncyc;
    if (t_err === 1'b1) begin
      t_err_at  = ncyc;
      t_err_cnt = t_err_cnt + 1;
    end
    if (t_out_valid === 1'b1) t_ov_cnt = t_ov_cnt + 1;
    t_prev_op = t_fir_op;
  end
`endif

  // ---------------- block driver (stimulus only) ----------------
  task automatic run_block(input logic [31:0] s [L], input int gap_pct, input int out_stall,
                           input bit noise, input bit stop_in_run, output bit timed_out);
    int idx, hold, base;
    timed_out = 1'b0;
    base = out_q.size();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < L; cyc++) begin
      if (in_ready && $urandom_range(99, 0) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = s[idx];
        idx++;
      end else if (in_ready) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'($urandom_range(1, 0));
        in_data  = $urandom;
      end
      start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < L) timed_out = 1'b1;
    if (stop_in_run) begin
      repeat (20) @(posedge clk);
      #1;
      return;
    end
    hold = 0;
    out_ready = (out_stall == 0);
    for (int cyc = 0; cyc < 3000 && out_q.size() < base + L; cyc++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'($urandom_range(1, 0));
      in_data  = $urandom;
      if (out_valid) begin
        if (noise && hold == 0) start = 1'b1;
        if (hold < out_stall) begin
          out_ready = 1'b0;
          hold++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        hold = 0;
        out_ready = (out_stall == 0);
      end
    end
    if (out_q.size() < base + L) timed_out = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({in_ready, out_valid, out_last, block_done, fir_reset} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got %b want 00000", {in_ready, out_valid, out_last, block_done, fir_reset}); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (fir_operation !== 2'b00 || fir_addr !== 32'd0 || fir_x_rns !== 32'd0) begin
      n_bad++; $display("FAIL reset_core_ctl got op=%b addr=%h x=%h want zeros", fir_operation, fir_addr, fir_x_rns); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset busy got %b want 0", busy); end
  endtask

  task automatic test_impulse();
    logic [31:0] s [L];
    logic [31:0] got;
    bit to;
    int bo, bw, bd, b10;
    for (int j = 0; j < L; j++) s[j] = 32'd0;
    s[0] = 32'h01010101;
    bo = out_q.size(); bw = wr_addr_q.size(); bd = done_cnt; b10 = op10_nd;
    run_block(s, 0, 0, 1'b0, 1'b0, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL impulse_timeout got %b want 0", to); end
    for (int j = 0; j < L; j++) begin
      got = (bo + j < out_q.size()) ? out_q[bo + j] : 32'hxxxxxxxx;
      n_cmp++; if (got !== fir_out(s, j)) begin n_bad++; $display("FAIL impulse_out[%0d] got %h want %h", j, got, fir_out(s, j)); end
      n_cmp++; if (bo + j >= last_q.size() || last_q[bo + j] !== (j == L - 1)) begin
        n_bad++; $display("FAIL impulse_last[%0d] wrong, want %0d", j, (j == L - 1)); end
    end
    got = (bo + 3 < out_q.size()) ? out_q[bo + 3] : 32'hxxxxxxxx;
    n_cmp++; if (got !== 32'h0B0B0B0B) begin n_bad++; $display("FAIL impulse_coef3 got %h want 0b0b0b0b", got); end
    got = (bo + 4 < out_q.size()) ? out_q[bo + 4] : 32'hxxxxxxxx;
    n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL impulse_tail got %h want 0", got); end
    n_cmp++; if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL impulse_block_done got %0d pulses want 1", done_cnt - bd); end
    n_cmp++; if (op10_nd - b10 !== RUN_CYCLES) begin n_bad++; $display("FAIL impulse_run_len got %0d want %0d", op10_nd - b10, RUN_CYCLES); end
    n_cmp++; if (wr_addr_q.size() - bw !== L) begin n_bad++; $display("FAIL impulse_writes got %0d want %0d", wr_addr_q.size() - bw, L); end
    n_cmp++; if (last_err !== 0) begin n_bad++; $display("FAIL out_last_without_valid got %0d want 0", last_err); end
  endtask

  task automatic test_input_stall();
    logic [31:0] s [L];
    logic [31:0] got;
    bit to;
    int bo, bw;
    for (int j = 0; j < L; j++) s[j] = rand_sample();
    bo = out_q.size(); bw = wr_addr_q.size();
    run_block(s, 50, 0, 1'b0, 1'b0, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stall_timeout got %b want 0", to); end
    n_cmp++; if (wr_addr_q.size() - bw !== L) begin n_bad++; $display("FAIL stall_writes got %0d want %0d", wr_addr_q.size() - bw, L); end
    for (int j = 0; j < L && bw + j < wr_addr_q.size(); j++) begin
      n_cmp++; if (wr_addr_q[bw + j] !== 32'(j) || wr_data_q[bw + j] !== s[j]) begin
        n_bad++; $display("FAIL stall_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", j, wr_addr_q[bw + j], wr_data_q[bw + j], j, s[j]); end
    end
    for (int j = 0; j < L; j++) begin
      got = (bo + j < out_q.size()) ? out_q[bo + j] : 32'hxxxxxxxx;
      n_cmp++; if (got !== fir_out(s, j)) begin n_bad++; $display("FAIL stall_out[%0d] got %h want %h", j, got, fir_out(s, j)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s [L];
    logic [31:0] got;
    bit to;
    int bo, bs;
    for (int j = 0; j < L; j++) s[j] = rand_sample();
    bo = out_q.size(); bs = stab_err;
    run_block(s, 0, 5, 1'b0, 1'b0, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got %b want 0", to); end
    n_cmp++; if (stab_err - bs !== 0) begin n_bad++; $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err - bs); end
    n_cmp++; if (out_q.size() - bo !== L) begin n_bad++; $display("FAIL bp_count got %0d want %0d", out_q.size() - bo, L); end
    for (int j = 0; j < L; j++) begin
      got = (bo + j < out_q.size()) ? out_q[bo + j] : 32'hxxxxxxxx;
      n_cmp++; if (got !== fir_out(s, j)) begin n_bad++; $display("FAIL bp_out[%0d] got %h want %h", j, got, fir_out(s, j)); end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] s [L];
    logic [31:0] got;
    bit to;
    int bo, bd, bc;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < L; j++) s[j] = rand_sample();
      bo = out_q.size(); bd = done_cnt; bc = clr_cnt;
      run_block(s, 30, 1, (b == 0), 1'b0, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL start_blk%0d_timeout got %b want 0", b, to); end
      n_cmp++; if (clr_cnt - bc !== 1) begin n_bad++; $display("FAIL start_blk%0d_clears got %0d want 1", b, clr_cnt - bc); end
      n_cmp++; if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL start_blk%0d_done got %0d want 1", b, done_cnt - bd); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_blk%0d_idle busy got %b want 0", b, busy); end
      for (int j = 0; j < L; j++) begin
        got = (bo + j < out_q.size()) ? out_q[bo + j] : 32'hxxxxxxxx;
        n_cmp++; if (got !== fir_out(s, j)) begin n_bad++; $display("FAIL start_blk%0d_out[%0d] got %h want %h", b, j, got, fir_out(s, j)); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s [L];
    logic [31:0] got;
    bit to;
    int bo;
    for (int j = 0; j < L; j++) s[j] = rand_sample();
    run_block(s, 0, 0, 1'b0, 1'b1, to);
    n_cmp++; if (fir_operation !== 2'b10) begin n_bad++; $display("FAIL midrun_in_run got op=%b want 10", fir_operation); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy, in_ready, out_valid, out_last, block_done, fir_reset} !== 6'b0) begin
      n_bad++; $display("FAIL midrun_reset_flags got %b want 000000", {busy, in_ready, out_valid, out_last, block_done, fir_reset}); end
    n_cmp++; if (out_data !== 32'd0 || fir_operation !== 2'b00 || fir_addr !== 32'd0) begin
      n_bad++; $display("FAIL midrun_reset_data got data=%h op=%b addr=%h want zeros", out_data, fir_operation, fir_addr); end
    reset = 1'b0;
    for (int j = 0; j < L; j++) s[j] = rand_sample();
    bo = out_q.size();
    run_block(s, 20, 2, 1'b0, 1'b0, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL midrun_next_timeout got %b want 0", to); end
    for (int j = 0; j < L; j++) begin
      got = (bo + j < out_q.size()) ? out_q[bo + j] : 32'hxxxxxxxx;
      n_cmp++; if (got !== fir_out(s, j)) begin n_bad++; $display("FAIL midrun_next_out[%0d] got %h want %h", j, got, fir_out(s, j)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s [L];
    logic [31:0] got;
    bit to;
    int bo, bw;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < L; j++) s[j] = rand_sample();
      bo = out_q.size(); bw = wr_addr_q.size();
      run_block(s, $urandom_range(60, 0), $urandom_range(3, 0), 1'b0, 1'b0, to);
      n_cmp++; if (to !== 1'b0 || wr_addr_q.size() - bw !== L) begin
        n_bad++; $display("FAIL b2b%0d_load got timeout=%b writes=%0d want 0/%0d", b, to, wr_addr_q.size() - bw, L); end
      for (int j = 0; j < L; j++) begin
        got = (bo + j < out_q.size()) ? out_q[bo + j] : 32'hxxxxxxxx;
        n_cmp++; if (got !== fir_out(s, j)) begin n_bad++; $display("FAIL b2b%0d_out[%0d] got %h want %h", b, j, got, fir_out(s, j)); end
      end
    end
  endtask

`ifdef FIR_RNS_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int be;
    be = t_err_cnt;
    @(posedge clk); #1;
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    for (int cyc = 0; cyc < 300 && t_err_cnt == be; cyc++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (t_err_cnt - be !== 1) begin n_bad++; $display("FAIL timeout_pulses got %0d want 1", t_err_cnt - be); end
    n_cmp++; if (t_err_at - t_run_at !== 50) begin n_bad++; $display("FAIL timeout_delay got %0d want 50", t_err_at - t_run_at); end
    n_cmp++; if (t_ov_cnt !== 0) begin n_bad++; $display("FAIL timeout_out_valid got %0d cycles want 0", t_ov_cnt); end
    n_cmp++; if (t_busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle busy got %b want 0", t_busy); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_impulse();
    test_input_stall();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
`ifdef FIR_RNS_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
